priority_dec_stage: RTL and testbench
=====================================

// Module: priority_dec_stage
// PURPOSE
//  Registered binary-to-one-hot decoder with valid/ready handshake; inverse of the 8:3 priority encoder.
//  Takes an encoded index plus IDLE flag and drives a one-hot line vector to downstream consumers.
//  Output holds until accepted; an optional inter-transaction gap spaces successive grants.
// PARAMETERS
//  N           8   number of one-hot output lines (N >= 2)
//  W           3   code width; must equal $clog2(N)
//  GAP_CYCLES  2   dead cycles after each output handshake before next accept (0 = none)
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_code    in   W    encoded line index (encoder y)
//  in_idle    in   1    encoder IDLE: no line requested
//  in_valid   in   1    in_code/in_idle valid
//  in_ready   out  1    stage can accept input this cycle
//  out_onehot out  N    decoded one-hot vector
//  out_valid  out  1    out_onehot valid
//  out_ready  in   1    downstream accepts out_onehot
//  err        out  1    sticky illegal-code flag (PRIO_DEC_ERR_EN only; else tied 0)
//  err_clr    in   1    synchronous clear of err (ignored without PRIO_DEC_ERR_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_IDLE, out_onehot=0, out_valid=0, gap counter=0, err=0.
//  in_ready = (state==S_IDLE); combinational from state only, no path from out_ready.
//  FSM:
//   S_IDLE: in_valid&&in_ready -> register decode, out_valid=1 next cycle, go S_OUT.
//   S_OUT : out_onehot/out_valid held stable until out_ready=1.
//           out_valid&&out_ready -> out_valid=0, out_onehot=0 next cycle;
//           go S_GAP with cnt=GAP_CYCLES-1, or S_IDLE if GAP_CYCLES==0.
//   S_GAP : in_ready=0; cnt decrements each cycle; cnt==0 -> S_IDLE.
//  Latency: accept at edge k -> out_valid high after edge k (visible cycle k+1).
//  Throughput: one transaction per (2+GAP_CYCLES) cycles at best.
//  Decode: out_onehot[j]=1 iff j==in_code, in_idle=0 and in_code<N; else all zero.
//  in_idle=1: legal transaction, out_onehot=0, out_valid still asserted; in_code ignored.
//  in_code>=N with in_idle=0 (only possible when N<2^W): out_onehot=0, out_valid asserted.
//  in_valid while in_ready=0: ignored, no sampling; upstream must hold it.
//  Reset mid-transaction: pending output discarded, no handshake completed.
//  Async reset assert; deassert assumed synchronised externally to clk.
// CONFIGURATION
//  PRIO_DEC_ERR_EN defined: accepting in_code>=N with in_idle=0 sets err the same edge
//   as the output register loads; err stays 1 until err_clr=1 (clear next edge).
//   Set and clear in the same cycle: set wins.
//  PRIO_DEC_ERR_EN undefined: err tied 0, err_clr unused, no error logic.
// TESTING
//  1. rst_n=0 mid-S_OUT -> out_valid=0, out_onehot=0, in_ready=1 immediately (async).
//  2. in_code=5, in_idle=0, out_ready=1 -> out_onehot=8'b0010_0000 one cycle after accept;
//     in_ready low 1+GAP_CYCLES cycles (3 at default).
//  3. in_code=3, out_ready=0 for 4 cycles -> out_onehot=8'h08 held stable, out_valid=1,
//     in_valid pulses ignored; accepted on the cycle out_ready=1.
//  4. in_idle=1, in_code=7 -> out_valid=1, out_onehot=8'h00.
//  5. N=6, in_code=6 (ERR_EN) -> out_onehot=0, err=1 sticky; err_clr=1 with a second
//     illegal code on the same cycle -> err stays 1.
//  6. GAP_CYCLES=0, back-to-back codes 0..7 -> one output per 2 cycles,
//     one-hot 01,02,04..80 in order.

Source files
------------

// File: rtl/priority_dec_stage.sv
// priority_dec_stage: registered binary-to-one-hot decoder with valid/ready handshake and post-grant gap.
// Optional sticky illegal-code flag enabled by defining PRIO_DEC_ERR_EN.
module priority_dec_stage #(
  parameter int N          = 8,
  parameter int W          = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_code,
  input  logic         in_idle,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  input  logic         err_clr
);
  localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_OUT, S_GAP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0] onehot_d, dec;
  logic illegal;
  // codes at or above N only exist when N is not a power of two
  assign illegal   = !in_idle && ({1'b0, in_code} >= (W+1)'(N));
  assign dec       = (in_idle || illegal) ? '0 : N'(1) << in_code;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_OUT;
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    onehot_d = out_onehot;
    case (state)
      S_IDLE: if (in_valid) begin
        onehot_d = dec;
        state_d  = S_OUT;
      end
      S_OUT: if (out_ready) begin
        onehot_d = '0;
        cnt_d    = CW'(GAP_CYCLES - 1);
        state_d  = GAP_CYCLES == 0 ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        cnt_d   = cnt - 1'b1;
        state_d = cnt == '0 ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_onehot <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      out_onehot <= onehot_d;
    end
  end
`ifdef PRIO_DEC_ERR_EN
  // a new illegal accept beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else err <= (in_valid && in_ready && illegal) ? 1'b1 : err_clr ? 1'b0 : err;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_priority_dec_stage.sv
// tb_priority_dec_stage: table vectors plus handshake corner sequences on three configurations.
module tb_priority_dec_stage;
`ifdef PRIO_DEC_ERR_EN
  localparam logic [31:0] E = 1;
`else
  localparam logic [31:0] E = 0;
`endif
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic [2:0] a_code, b_code, c_code;
  logic a_idle, a_valid, a_ir, a_ov, a_or, a_err, a_clr;
  logic b_idle, b_valid, b_ir, b_ov, b_or, b_err, b_clr;
  logic c_idle, c_valid, c_ir, c_ov, c_or, c_err, c_clr;
  logic [7:0] a_oh, b_oh;
  logic [5:0] c_oh;
  priority_dec_stage dut_a (.clk(clk), .rst_n(rst_n), .in_code(a_code), .in_idle(a_idle),
    .in_valid(a_valid), .in_ready(a_ir), .out_onehot(a_oh), .out_valid(a_ov),
    .out_ready(a_or), .err(a_err), .err_clr(a_clr));
  priority_dec_stage #(.GAP_CYCLES(0)) dut_b (.clk(clk), .rst_n(rst_n), .in_code(b_code),
    .in_idle(b_idle), .in_valid(b_valid), .in_ready(b_ir), .out_onehot(b_oh),
    .out_valid(b_ov), .out_ready(b_or), .err(b_err), .err_clr(b_clr));
  priority_dec_stage #(.N(6)) dut_c (.clk(clk), .rst_n(rst_n), .in_code(c_code),
    .in_idle(c_idle), .in_valid(c_valid), .in_ready(c_ir), .out_onehot(c_oh),
    .out_valid(c_ov), .out_ready(c_or), .err(c_err), .err_clr(c_clr));
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  typedef struct {logic [2:0] code; logic idle; logic [7:0] exp;} vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic rdy(input int s);
    return s == 0 ? a_ir : s == 1 ? b_ir : c_ir;
  endfunction
  task automatic wait_rdy(input int s, input string nm);
    int n = 0;
    while (!rdy(s) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy(s)) begin
      failures++;
      $display("FAIL %s_timeout: in_ready low after %0d cycles", nm, n);
    end
  endtask
  task automatic send(input logic [2:0] c, input logic id, input logic [7:0] e);
    a_code = c;
    a_idle = id;
    a_valid = 1;
    wait_rdy(0, "send");
    if (a_ir) q.push_back(e);
    @(posedge clk);
    #1 a_valid = 0;
  endtask
  always @(negedge clk)
    if (rst_n && a_ov && a_or) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h expected no output", a_oh);
      end else chk("sb", a_oh, q.pop_front());
    end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    {a_code, a_idle, a_valid, a_clr} = '0;
    {b_code, b_idle, b_valid, b_clr} = '0;
    {c_code, c_idle, c_valid, c_clr} = '0;
    {a_or, b_or, c_or} = 3'b111;
    tbl[0] = '{3'd5, 1'b0, 8'h20};
    tbl[1] = '{3'd0, 1'b0, 8'h01};
    tbl[2] = '{3'd7, 1'b0, 8'h80};
    tbl[3] = '{3'd3, 1'b0, 8'h08};
    tbl[4] = '{3'd7, 1'b1, 8'h00};
    tbl[5] = '{3'd2, 1'b1, 8'h00};
    tbl[6] = '{3'd1, 1'b0, 8'h02};
    tbl[7] = '{3'd6, 1'b0, 8'h40};
    #2 rst_n = 0;
    #10;
    chk("rst_ready", a_ir, 1);
    chk("rst_valid", a_ov, 0);
    chk("rst_onehot", a_oh, 0);
    chk("rst_err", c_err, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 8; i++) send(tbl[i].code, tbl[i].idle, tbl[i].exp);
    wait_rdy(0, "t2_idle");
    chk("t2_pre_ready", a_ir, 1);
    a_code = 5;
    a_idle = 0;
    a_valid = 1;
    q.push_back(8'h20);
    @(posedge clk);
    #1 a_valid = 0;
    @(negedge clk);
    chk("t2_valid", a_ov, 1);
    chk("t2_onehot", a_oh, 8'h20);
    chk("t2_busy0", a_ir, 0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t2_busy%0d", i), a_ir, 0);
    end
    @(negedge clk);
    chk("t2_ready_again", a_ir, 1);
    a_or = 0;
    send(3'd3, 1'b0, 8'h08);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", a_ov, 1);
      chk("t3_hold_onehot", a_oh, 8'h08);
      a_code = 1;
      a_valid = 1;
    end
    @(posedge clk);
    #1 a_valid = 0;
    a_or = 1;
    repeat (6) @(negedge clk);
    chk("t3_no_extra", a_ov, 0);
    wait_rdy(0, "t1_idle");
    a_or = 0;
    a_code = 4;
    a_valid = 1;
    @(posedge clk);
    #1 a_valid = 0;
    @(negedge clk);
    chk("t1_pre_valid", a_ov, 1);
    #2 rst_n = 0;
    #1;
    chk("t1_async_valid", a_ov, 0);
    chk("t1_async_onehot", a_oh, 0);
    chk("t1_async_ready", a_ir, 1);
    @(negedge clk) rst_n = 1;
    a_or = 1;
    @(negedge clk);
    chk("t1_after_valid", a_ov, 0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'(1) << i;
      @(negedge clk);
      chk("t6_ready", b_ir, 1);
      b_code = 3'(i);
      b_valid = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_valid", b_ov, 1);
      chk("t6_onehot", b_oh, e);
      chk("t6_busy", b_ir, 0);
      @(posedge clk);
      #1;
    end
    b_valid = 0;
    wait_rdy(2, "t5_idle");
    c_code = 6;
    c_idle = 0;
    c_valid = 1;
    @(posedge clk);
    #1 c_valid = 0;
    @(negedge clk);
    chk("t5_valid", c_ov, 1);
    chk("t5_onehot", c_oh, 0);
    chk("t5_err_set", c_err, E);
    wait_rdy(2, "t5_idle2");
    chk("t5_err_sticky", c_err, E);
    c_code = 7;
    c_valid = 1;
    c_clr = 1;
    @(posedge clk);
    #1 c_valid = 0;
    c_clr = 0;
    @(negedge clk);
    chk("t5_set_wins", c_err, E);
    chk("t5_onehot7", c_oh, 0);
    wait_rdy(2, "t5_idle3");
    c_clr = 1;
    @(posedge clk);
    #1 c_clr = 0;
    @(negedge clk);
    chk("t5_err_clr", c_err, 0);
    c_code = 5;
    c_valid = 1;
    @(posedge clk);
    #1 c_valid = 0;
    @(negedge clk);
    chk("t5_legal", c_oh, 6'b100000);
    chk("t5_legal_err", c_err, 0);
    chk("a_err_zero", a_err, 0);
    repeat (5) @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
